// File: rtl/if_inst_queue_pkg.sv
// Shared definitions for the instruction queue between fetch and decode.
//   NOP_INST   : word shown to the decoder whenever the queue is empty
//                (andi r0,r0,0).
//   iq_entry_t : one buffered fetch entry {pc, inst, adef}.
package if_inst_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h0340_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } iq_entry_t;

endpackage

// File: rtl/if_inst_queue.sv
// Instruction buffer between the icache return path and the decode stage.
// Holds up to DEPTH entries in fetch order. The oldest entry is presented
// to the decoder. A redirect flush drops all contents.
//
// Ports:
//   clk       : core clock
//   rst       : synchronous reset, active-high; highest priority
//   flush     : redirect; the queue is empty on the next cycle
//   in_valid  : fetch entry offered this cycle
//   in_pc     : PC of the offered instruction
//   in_inst   : offered instruction word
//   in_ready  : the queue can accept an entry (registered state only)
//   out_valid : the head entry is valid (decoder data_valid)
//   out_pc    : PC of the head entry, or 0 when empty
//   out_inst  : instruction of the head entry (IF_IR), or NOP_INST when empty
//   out_adef  : the head PC was misaligned at push time
//   out_ready : decode consumes the head entry this cycle
//   count     : current occupancy, 0..DEPTH
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic             out_adef,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  iq_entry_t        head;

  // in_ready depends only on the registered count. A pop while full does not
  // open a slot in the same cycle, which keeps out_ready off the fetch path.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
  // naturally.
  // NOTE: sequential state uses non-blocking assignments. This keeps every
  // register reading the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage. The adef flag is captured from the PC alignment at push.
  // NOTE: the storage array has no reset. Only count and the pointers decide
  // what is visible, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst, adef: |in_pc[1:0]};
    end
  end

  // Head read is combinational. An empty queue shows the NOP encoding.
  // NOTE: every always_comb output is given a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    head     = mem[rd_ptr];
    out_pc   = 32'h0;
    out_inst = NOP_INST;
    out_adef = 1'b0;
    if (out_valid) begin
      out_pc   = head.pc;
      out_inst = head.inst;
      out_adef = head.adef;
    end
  end

endmodule
